// File: rtl/plane_recip_pkg.sv
// Shared constants for the plane-stage reciprocal unit and the renderer's plane_du path.
package plane_recip_pkg;

    localparam int RECIP_NUM_LOG2 = 16;
    localparam int RECIP_DEN_W    = 16;
    localparam int RECIP_OUT_W    = 11;
    localparam logic [RECIP_OUT_W-1:0] RECIP_SAT = {RECIP_OUT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } recip_state_t;

endpackage

// File: rtl/plane_recip.sv
// Per-scanline reciprocal: floor(2^NUM_LOG2 / denom), one restoring-division quotient bit per
// cycle, saturating to all-ones, with fixed latency for every operand.
module plane_recip
    import plane_recip_pkg::*;
#(
    parameter int NUM_LOG2 = RECIP_NUM_LOG2,
    parameter int DEN_W    = RECIP_DEN_W,
    parameter int OUT_W    = RECIP_OUT_W
) (
    input  logic             clk48,
    input  logic             rst,
    input  logic             start,
    input  logic [DEN_W-1:0] denom,
    output logic [OUT_W-1:0] recip,
    output logic             busy,
    output logic             done
);

    localparam int REM_W = DEN_W + 1;
    localparam int CNT_W = 4;
    // Numerator bits above the OUT_W quotient bits collapse to this starting remainder,
    // which is also the largest denominator whose quotient overflows OUT_W bits.
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(2 ** (NUM_LOG2 - OUT_W));
    localparam logic [OUT_W-1:0] SAT_VAL  = {OUT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    function automatic logic sat_check(input logic [DEN_W-1:0] d);
        return (d == '0) || ({1'b0, d} <= REM_INIT);
    endfunction

    recip_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [DEN_W-1:0] den;
    logic [REM_W-1:0] rem;
    logic [OUT_W-1:0] quo;

    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] diff;
    logic             take;

    always_comb begin
        rem_sh = rem << 1;
        diff   = rem_sh - {1'b0, den};
        take   = (rem_sh >= {1'b0, den});
    end

    // Control and visible result: a start always wins over the current step, but a WRITE
    // in the same cycle still lands its result.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            recip <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    recip <= sat ? SAT_VAL : quo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: ;
            endcase
            if (start) begin
                state <= ST_RUN;
                cnt   <= '0;
                busy  <= 1'b1;
                sat   <= sat_check(denom);
            end
        end
    end

    // Datapath: operand capture and one restoring-division step per RUN cycle.
    always_ff @(posedge clk48) begin
        if (start) begin
            den <= denom;
            rem <= REM_INIT;
            quo <= '0;
        end else if (state == ST_RUN) begin
            rem <= take ? diff : rem_sh;
            quo <= {quo[OUT_W-2:0], take};
        end
    end

endmodule

// File: tb/tb_plane_recip.sv
// Scoreboard bench for plane_recip: stimulus queues expected results, a monitor checks them on done.
module tb_plane_recip;

    logic        clk48 = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [15:0] denom = '0;
    logic [10:0] recip;
    logic        busy;
    logic        done;

    plane_recip dut (
        .clk48(clk48),
        .rst  (rst),
        .start(start),
        .denom(denom),
        .recip(recip),
        .busy (busy),
        .done (done)
    );

    always #5 clk48 = ~clk48;

    typedef struct {
        int exp;
        int due;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        edges  = 0;
    int        n_cmp  = 0;
    int        n_fail = 0;

    always @(posedge clk48) edges = edges + 1;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, req, edges);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation, value and edge.
    always @(negedge clk48) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done actual=done recip=%0d required=no done (edge %0d)",
                         recip, edges);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check("recip", int'(recip), e.exp);
                check("done_edge", edges, e.due);
            end
        end
    end

    // Called at a negedge; start is sampled on the next rising edge (N), done due at N+12.
    task automatic launch(input int d, input int exp, input bit push);
        start = 1'b1;
        denom = 16'(d);
        if (push) sb_q.push_back('{exp: exp, due: edges + 13});
        @(negedge clk48);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb_q.size() > 0; i++) @(negedge clk48);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk48);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_v;
        int dd;

        // Reset state
        repeat (3) @(negedge clk48);
        check("reset_recip", int'(recip), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk48);

        // denom=34 with busy profile: high after edges N..N+11, low after N+12
        launch(34, 1927, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check("busy_run", int'(busy), 1);
            @(negedge clk48);
        end
        check("busy_after", int'(busy), 0);
        wait_idle();

        // Directed values, including saturation boundary and extremes
        launch(100, 655, 1'b1);    wait_idle();
        launch(512, 128, 1'b1);    wait_idle();
        launch(33, 1985, 1'b1);    wait_idle();
        launch(32, 2047, 1'b1);    wait_idle();
        launch(0, 2047, 1'b1);     wait_idle();
        launch(65535, 1, 1'b1);    wait_idle();
        launch(1, 2047, 1'b1);     wait_idle();
        launch(65, 1008, 1'b1);    wait_idle();

        // Abort: 100 then 512 at +5; only 128 may appear, at +17 of the first start
        launch(100, 655, 1'b0);
        repeat (4) @(negedge clk48);
        launch(512, 128, 1'b1);
        wait_idle();
        check("abort_recip_final", int'(recip), 128);

        // Back-to-back sweep: each start lands on the previous done edge
        for (int k = 0; k < 198; k++) begin
            dd = 33 + k * 331;
            launch(dd, 65536 / dd, 1'b1);
            repeat (11) @(negedge clk48);
        end
        wait_idle();

        // Reset mid-RUN with recip previously 655
        launch(100, 655, 1'b1);
        wait_idle();
        launch(34, 1927, 1'b0);
        repeat (5) @(negedge clk48);
        rst = 1'b1;
        #1;
        check("midrst_recip", int'(recip), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk48);
        rst = 1'b0;
        repeat (20) @(negedge clk48);
        check("postrst_recip", int'(recip), 0);
        check("postrst_busy", int'(busy), 0);

        // Cadence: start every 40 cycles, recip stable from +12 until the next start's result
        for (int line = 0; line < 10; line++) begin
            dd    = 40 + line * 50;
            exp_v = 65536 / dd;
            launch(dd, exp_v, 1'b1);
            for (int k = 1; k < 40; k++) begin
                @(negedge clk48);
                if (k >= 12) check("cadence_hold", int'(recip), exp_v);
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
